// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA exponentiation datapath: operand-mux select
// codes plus the square-and-multiply sequencer's state and operation encodings.
package rsa_pkg;

  localparam logic [1:0] SEL_ONE  = 2'b00;
  localparam logic [1:0] SEL_A    = 2'b01;
  localparam logic [1:0] SEL_B    = 2'b10;
  localparam logic [1:0] SEL_ZERO = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SCAN  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_WB    = 3'd4,
    ST_FIN   = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    OP_INIT = 2'd0,
    OP_SQ   = 2'd1,
    OP_MUL  = 2'd2,
    OP_ZERO = 2'd3
  } op_e;

  // {sel_x, sel_y} operand pair for each multiply kind
  function automatic logic [3:0] op_sel(input op_e op);
    logic [3:0] sel;
    case (op)
      OP_INIT: sel = {SEL_ONE, SEL_B};
      OP_SQ:   sel = {SEL_A, SEL_A};
      OP_MUL:  sel = {SEL_A, SEL_B};
      OP_ZERO: sel = {SEL_ONE, SEL_ONE};
      default: sel = {SEL_ZERO, SEL_ZERO};
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/modexp_seq_ctrl.sv
// Left-to-right square-and-multiply sequencer: walks the exponent MSB first,
// launches one modular multiply per step and commands result write-back.
module modexp_seq_ctrl
  import rsa_pkg::*;
#(
  parameter int EXP_W = 1024,
  parameter int IDX_W = $clog2(EXP_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [EXP_W-1:0] exponent,
  output logic             mult_start,
  input  logic             mult_done,
  output logic [1:0]       sel_x,
  output logic [1:0]       sel_y,
  output logic             res_we,
  output logic             busy,
  output logic             done
);

  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(EXP_W - 1);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  state_e             state_q;
  op_e                op_q;
  logic [EXP_W-1:0]   exp_q;
  logic [IDX_W-1:0]   idx_q;
  logic               mult_start_q;
  logic               res_we_q;
  logic               busy_q;
  logic               done_q;
  logic [1:0]         sel_x_q;
  logic [1:0]         sel_y_q;

  logic               cur_bit_s;
  logic               idx_zero_s;
  logic               issue_s;
  logic               fin_s;
  logic               dec_s;
  op_e                op_d;
  logic [3:0]         sel_d;

  assign cur_bit_s  = exp_q[idx_q];
  assign idx_zero_s = (idx_q == {IDX_W{1'b0}});
  assign sel_d      = op_sel(op_d);

  // Step decision shared by the leading-zero scan and the write-back state;
  // idx always names the exponent bit currently being processed.
  always_comb begin
    issue_s = 1'b0;
    fin_s   = 1'b0;
    dec_s   = 1'b0;
    op_d    = op_q;
    case (state_q)
      ST_SCAN: begin
        if (cur_bit_s) begin
          issue_s = 1'b1;
          op_d    = OP_INIT;
        end else if (idx_zero_s) begin
          issue_s = 1'b1;
          op_d    = OP_ZERO;
        end else begin
          dec_s = 1'b1;
        end
      end
      ST_WB: begin
        case (op_q)
          OP_INIT, OP_MUL: begin
            if (idx_zero_s) begin
              fin_s = 1'b1;
            end else begin
              dec_s   = 1'b1;
              issue_s = 1'b1;
              op_d    = OP_SQ;
            end
          end
          OP_SQ: begin
            if (cur_bit_s) begin
              issue_s = 1'b1;
              op_d    = OP_MUL;
            end else if (idx_zero_s) begin
              fin_s = 1'b1;
            end else begin
              dec_s   = 1'b1;
              issue_s = 1'b1;
              op_d    = OP_SQ;
            end
          end
          default: fin_s = 1'b1;
        endcase
      end
      default: begin
        issue_s = 1'b0;
      end
    endcase
  end

  // Sequencer FSM with all outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      op_q         <= OP_INIT;
      exp_q        <= {EXP_W{1'b0}};
      idx_q        <= {IDX_W{1'b0}};
      mult_start_q <= 1'b0;
      res_we_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      sel_x_q      <= SEL_ZERO;
      sel_y_q      <= SEL_ZERO;
    end else begin
      mult_start_q <= 1'b0;
      res_we_q     <= 1'b0;
      done_q       <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            exp_q   <= exponent;
            idx_q   <= IDX_MSB;
            busy_q  <= 1'b1;
            state_q <= ST_SCAN;
          end
        end
        ST_SCAN, ST_WB: begin
          if (dec_s) begin
            idx_q <= idx_q - IDX_ONE;
          end
          if (issue_s) begin
            op_q         <= op_d;
            sel_x_q      <= sel_d[3:2];
            sel_y_q      <= sel_d[1:0];
            mult_start_q <= 1'b1;
            state_q      <= ST_ISSUE;
          end else if (fin_s) begin
            sel_x_q <= SEL_ZERO;
            sel_y_q <= SEL_ZERO;
            done_q  <= 1'b1;
            state_q <= ST_FIN;
          end
        end
        ST_ISSUE: state_q <= ST_WAIT;
        ST_WAIT: begin
          if (mult_done) begin
            res_we_q <= 1'b1;
            state_q  <= ST_WB;
          end
        end
        ST_FIN: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mult_start = mult_start_q;
  assign res_we     = res_we_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign sel_x      = sel_x_q;
  assign sel_y      = sel_y_q;

endmodule

// File: tb/tb_modexp_seq_ctrl.sv
// Bench for modexp_seq_ctrl: a cycle timeline predicted from the exponent's bits,
// a delayed-reply multiplier model and an arithmetic scoreboard for base^e mod N.
module tb_modexp_seq_ctrl;
  import rsa_pkg::*;

  localparam int EXP_W = 8;
  localparam int IDX_W = 3;
  localparam int MAXL  = 2048;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] exponent = 8'h00;
  logic       mult_done = 1'b0;
  logic       mult_start, res_we, busy, done;
  logic [1:0] sel_x, sel_y;

  modexp_seq_ctrl #(.EXP_W(EXP_W), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .exponent(exponent),
    .mult_start(mult_start), .mult_done(mult_done), .sel_x(sel_x), .sel_y(sel_y),
    .res_we(res_we), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // multiplier model: replies md_delay cycles after each launch
  int     md_delay = 3;
  bit     spur_mode = 1'b0;
  bit     md_pend = 1'b0;
  int     md_cnt = 0;
  always @(negedge clk) begin
    mult_done <= 1'b0;
    if (md_pend) begin
      if (md_cnt == 1) begin
        mult_done <= 1'b1;
        md_pend   <= 1'b0;
      end
      md_cnt <= md_cnt - 1;
    end
    if (spur_mode && res_we === 1'b1) mult_done <= 1'b1;
    if (mult_start === 1'b1) begin
      md_pend <= 1'b1;
      md_cnt  <= md_delay;
    end
  end

  // datapath model: result register follows the DUT's selects on each write-back
  longint base_v = 0;
  longint mod_n = 1;
  longint acc = 0;
  function automatic longint pick(input logic [1:0] s, input longint a, input longint b);
    case (s)
      SEL_ONE: return 1;
      SEL_A:   return a;
      SEL_B:   return b;
      default: return 0;
    endcase
  endfunction
  always @(negedge clk) begin
    if (res_we === 1'b1) acc <= (pick(sel_x, acc, base_v) * pick(sel_y, acc, base_v)) % mod_n;
  end

  function automatic int msb_pos(input logic [7:0] e);
    for (int i = 7; i >= 0; i--) if (e[i]) return i;
    return -1;
  endfunction
  function automatic int n_ops(input logic [7:0] e);
    if (e == 8'h00) return 1;
    return 1 + msb_pos(e) + ($countones(e) - 1);
  endfunction
  function automatic int first_ms(input logic [7:0] e);
    if (e == 8'h00) return 2 + 7;
    return 2 + (7 - msb_pos(e));
  endfunction
  function automatic longint ref_pow(input longint b, input int e, input longint n);
    longint r;
    r = 1 % n;
    for (int i = 0; i < e; i++) r = (r * b) % n;
    return r;
  endfunction

  bit         t_ms [MAXL];
  bit         t_we [MAXL];
  bit         t_dn [MAXL];
  bit         t_busy [MAXL];
  logic [1:0] t_sx [MAXL];
  logic [1:0] t_sy [MAXL];
  int         t_len;

  task automatic build_trace(input logic [7:0] e, input int d, output int fin);
    logic [3:0] ops_q[$];
    int s;
    for (int k = 0; k < MAXL; k++) begin
      t_ms[k] = 1'b0; t_we[k] = 1'b0; t_dn[k] = 1'b0; t_busy[k] = 1'b0;
      t_sx[k] = SEL_ZERO; t_sy[k] = SEL_ZERO;
    end
    if (e == 8'h00) ops_q.push_back({SEL_ONE, SEL_ONE});
    else begin
      ops_q.push_back({SEL_ONE, SEL_B});
      for (int i = msb_pos(e) - 1; i >= 0; i--) begin
        ops_q.push_back({SEL_A, SEL_A});
        if (e[i]) ops_q.push_back({SEL_A, SEL_B});
      end
    end
    s = first_ms(e);
    foreach (ops_q[j]) begin
      for (int k = s; k <= s + d + 1; k++) {t_sx[k], t_sy[k]} = ops_q[j];
      t_ms[s] = 1'b1;
      t_we[s + d + 1] = 1'b1;
      s = s + d + 2;
    end
    fin = s;
    t_dn[fin] = 1'b1;
    for (int k = 1; k <= fin; k++) t_busy[k] = 1'b1;
    t_len = fin + 3;
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cmp_cycle(input int rel);
    n_vec++;
    if (mult_start !== t_ms[rel] || res_we !== t_we[rel] || done !== t_dn[rel] ||
        busy !== t_busy[rel] || sel_x !== t_sx[rel] || sel_y !== t_sy[rel]) begin
      n_err++;
      $display("FAIL trace rel=%0d: got ms=%b we=%b done=%b busy=%b sx=%b sy=%b, expected ms=%b we=%b done=%b busy=%b sx=%b sy=%b",
               rel, mult_start, res_we, done, busy, sel_x, sel_y,
               t_ms[rel], t_we[rel], t_dn[rel], t_busy[rel], t_sx[rel], t_sy[rel]);
    end
  endtask

  task automatic run_op(input logic [7:0] e, input int d, input bit inj,
                        input longint b, input longint n);
    int fin, nms, nwe, ndn, first;
    nms = 0; nwe = 0; ndn = 0; first = -1;
    md_delay = d; spur_mode = inj; base_v = b; mod_n = n;
    build_trace(e, d, fin);
    @(posedge clk); #1;
    start = 1'b1; exponent = e;
    for (int rel = 0; rel < t_len; rel++) begin
      if (rel > 0) begin
        @(posedge clk); #1;
        start = inj && (rel == 20 || rel == fin);
        exponent = 8'($urandom);
      end
      @(negedge clk);
      cmp_cycle(rel);
      if (mult_start === 1'b1) begin
        nms++;
        if (first < 0) first = rel;
      end
      if (res_we === 1'b1) nwe++;
      if (done === 1'b1) ndn++;
    end
    start = 1'b0;
    spur_mode = 1'b0;
    chk($sformatf("first_ms_%02h", e), longint'(first), longint'(first_ms(e)));
    chk($sformatf("mult_starts_%02h", e), longint'(nms), longint'(n_ops(e)));
    chk($sformatf("res_we_count_%02h", e), longint'(nwe), longint'(n_ops(e)));
    chk($sformatf("done_count_%02h", e), longint'(ndn), 64'sd1);
    chk($sformatf("result_%02h", e), acc, ref_pow(b, int'(e), n));
  endtask

  task automatic reset_midrun;
    int nms, k, late;
    md_delay = 3; spur_mode = 1'b0; base_v = 5; mod_n = 97;
    @(posedge clk); #1;
    start = 1'b1; exponent = 8'h0B;
    @(posedge clk); #1;
    start = 1'b0;
    nms = 0; k = 0;
    while (nms < 3 && k < 200) begin
      @(negedge clk);
      if (mult_start === 1'b1) nms++;
      k++;
    end
    chk("rst_reach_op3", longint'(nms), 64'sd3);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_outputs", longint'({mult_start, res_we, busy, done, sel_x, sel_y}), longint'(8'h0F));
    @(posedge clk); #1;
    rst_n = 1'b1;
    late = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (mult_done === 1'b1) late++;
      chk("post_rst_quiet", longint'({mult_start, res_we, done, busy, sel_x, sel_y}), longint'(8'h0F));
    end
    chk("late_done_seen", longint'(late), 64'sd1);
  endtask

  initial begin
    logic [7:0] e;
    int d;
    longint n, b;
    chk("model_ops_0B", longint'(n_ops(8'h0B)), 64'sd6);
    chk("model_ops_00", longint'(n_ops(8'h00)), 64'sd1);
    chk("model_ops_80", longint'(n_ops(8'h80)), 64'sd8);
    chk("model_ops_FF", longint'(n_ops(8'hFF)), 64'sd15);
    chk("model_lat_0B", longint'(first_ms(8'h0B)), 64'sd6);
    chk("model_lat_00", longint'(first_ms(8'h00)), 64'sd9);
    chk("model_lat_80", longint'(first_ms(8'h80)), 64'sd2);
    chk("model_pow_3_11", ref_pow(3, 11, 1000), 64'sd147);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state", longint'({mult_start, res_we, busy, done, sel_x, sel_y}), longint'(8'h0F));
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_op(8'h0B, 3, 1'b0, 3, 1000);
    chk("acc_3_pow_11", acc, 64'sd147);
    run_op(8'h00, 3, 1'b0, 7, 1000);
    chk("acc_pow_0", acc, 64'sd1);
    run_op(8'h80, 3, 1'b0, 2, 1001);
    run_op(8'hFF, 3, 1'b1, 3, 65521);
    reset_midrun();
    run_op(8'h0B, 3, 1'b0, 3, 1000);
    run_op(8'h0B, 50, 1'b0, 12, 9973);
    run_op(8'h01, 1, 1'b0, 9, 31);

    for (int r = 0; r < 12; r++) begin
      e = 8'($urandom);
      d = int'($urandom_range(1, 6));
      n = longint'($urandom_range(3, 60000)) | 64'sd1;
      b = longint'($urandom_range(0, 60000)) % n;
      run_op(e, d, r[0], b, n);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
